// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path.
// Holds the default frame geometry, the complex sample type, the read-FSM
// state type and the index bit-reversal helper.
package fft_pkg;

    localparam int FFT_N   = 128;
    localparam int FFT_NUM = $clog2(FFT_N);
    localparam int FFT_DW  = 16;

    typedef struct packed {
        logic [FFT_DW-1:0] re;
        logic [FFT_DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    // Reverses the low 'width' bits of 'val'; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res[width-1-i] = val[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two-bank sample store for the reorder buffer.
// One synchronous write port and one asynchronous (combinational) read port.
// Contents are not reset.
//
// Ports:
//   clk      - clock, write on rising edge
//   we       - write enable
//   wr_bank  - bank selected for the write
//   wr_addr  - write address within the bank
//   wr_data  - packed {re, im} sample to store
//   rd_bank  - bank selected for the read
//   rd_addr  - read address within the bank
//   rd_data  - packed {re, im} sample at rd_bank/rd_addr
module fft_pingpong_bank
    import fft_pkg::*;
#(
    parameter int N   = FFT_N,
    parameter int NUM = $clog2(N),
    parameter int W   = 2 * FFT_DW
) (
    input  logic           clk,
    input  logic           we,
    input  logic           wr_bank,
    input  logic [NUM-1:0] wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           rd_bank,
    input  logic [NUM-1:0] rd_addr,
    output logic [W-1:0]   rd_data
);

    logic [W-1:0] mem_q [2][N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame reorder buffer between the counter-indexed FFT datapath and
// the output stream. One bank fills from in_idx while the other drains on a
// valid/ready stream; writes never stall.
//
// Build option:
//   FFT_REORDER_BITREV_EN defined   -> frame replayed at address bitrev(r)
//   FFT_REORDER_BITREV_EN undefined -> frame replayed at address r (pass-through)
//
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   in_valid, in_start - a sample is written only when both are high
//   in_idx             - write address within the frame
//   in_re, in_im       - incoming sample
//   out_valid/out_ready- output handshake
//   out_idx, out_last  - output position in the frame, high on position N-1
//   out_re, out_im     - outgoing sample
//   ovf                - sticky: a sample arrived while its bank was still full
//
// Read FSM:
//   state     | meaning
//   ST_IDLE   | no complete frame waiting in bank rb
//   ST_STREAM | draining bank rb into the output register, position r
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N   = FFT_N,
    parameter int NUM = $clog2(N),
    parameter int DW  = FFT_DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           in_start,
    input  logic [NUM-1:0] in_idx,
    input  logic [DW-1:0]  in_re,
    input  logic [DW-1:0]  in_im,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NUM-1:0] out_idx,
    output logic           out_last,
    output logic [DW-1:0]  out_re,
    output logic [DW-1:0]  out_im,
    output logic           ovf
);

    localparam logic [NUM-1:0] LAST = NUM'(N - 1);

    rd_state_t      state_q, state_d;
    logic [NUM-1:0] r_q, r_d;
    logic           wb_q, wb_d;
    logic           rb_q, rb_d;
    logic [1:0]     full_q, full_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [NUM-1:0] out_idx_q, out_idx_d;
    logic [DW-1:0]  out_re_q, out_re_d;
    logic [DW-1:0]  out_im_q, out_im_d;

    logic            wr_req;
    logic            wr_en;
    logic            wr_done;
    logic            load;
    logic            rd_done;
    logic [NUM-1:0]  rd_addr;
    logic [2*DW-1:0] rd_data;

    fft_pingpong_bank #(
        .N   (N),
        .NUM (NUM),
        .W   (2 * DW)
    ) u_bank (
        .clk     (clk),
        .we      (wr_en),
        .wr_bank (wb_q),
        .wr_addr (in_idx),
        .wr_data ({in_re, in_im}),
        .rd_bank (rb_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
`ifdef FFT_REORDER_BITREV_EN
        rd_addr = NUM'(bitrev(32'(r_q), NUM));
`else
        rd_addr = r_q;
`endif
    end

    always_comb begin
        wr_req  = in_valid && in_start;
        wr_en   = wr_req && !full_q[wb_q];
        wr_done = wr_en && (in_idx == LAST);
        load    = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
        rd_done = load && (r_q == LAST);

        state_d     = state_q;
        r_d         = r_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;

        if (wr_req && full_q[wb_q]) begin
            ovf_d = 1'b1;
        end

        // Write completion and drain completion always target different
        // banks (one is full, the other is not), so both updates can land
        // on the same edge.
        if (wr_done) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        if (rd_done) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rb_q]) begin
                    state_d = ST_STREAM;
                    r_d     = '0;
                end
            end
            ST_STREAM: begin
                if (load) begin
                    r_d = r_q + NUM'(1);
                    if (rd_done) begin
                        r_d     = '0;
                        state_d = full_q[~rb_q] ? ST_STREAM : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = r_q;
            out_last_d  = (r_q == LAST);
            out_re_d    = rd_data[2*DW-1:DW];
            out_im_d    = rd_data[DW-1:0];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: directed frames, scoreboard queue filled by
// the stimulus side and drained by an independent output monitor.
module tb_fft_bitrev_reorder;

    localparam int N   = 128;
    localparam int NUM = 7;
    localparam int DW  = 16;

`ifdef FFT_REORDER_BITREV_EN
    localparam int SECOND_RE = 64;   // bitrev(1) for a 7-bit index
`else
    localparam int SECOND_RE = 1;
`endif

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_start;
    logic [NUM-1:0] in_idx;
    logic [DW-1:0]  in_re;
    logic [DW-1:0]  in_im;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [NUM-1:0] out_idx;
    logic           out_last;
    logic [DW-1:0]  out_re;
    logic [DW-1:0]  out_im;
    logic           ovf;

    typedef struct {
        int          idx;
        logic [15:0] re;
        logic [15:0] im;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    fft_bitrev_reorder #(
        .N   (N),
        .NUM (NUM),
        .DW  (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_idx    (in_idx),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_re    (out_re),
        .out_im    (out_im),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int addr_of(input int r);
`ifdef FFT_REORDER_BITREV_EN
        int res = 0;
        for (int i = 0; i < NUM; i++) begin
            if (((r >> i) & 1) != 0) res |= (1 << (NUM - 1 - i));
        end
        return res;
`else
        return r;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int base);
        exp_t e;
        for (int r = 0; r < N; r++) begin
            e.idx  = r;
            e.re   = 16'(base + addr_of(r));
            e.im   = ~16'(base + addr_of(r));
            e.last = (r == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; each index is written by the following edge.
    task automatic send_range(input int base, input int lo, input int hi, input bit start);
        for (int i = lo; i <= hi; i++) begin
            in_valid = 1'b1;
            in_start = start;
            in_idx   = NUM'(i);
            in_re    = 16'(base + i);
            in_im    = ~16'(base + i);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_last"},  32'(out_last),  0);
        check({tag, "_idx"},   32'(out_idx),   0);
        check({tag, "_re"},    32'(out_re),    0);
        check({tag, "_im"},    32'(out_im),    0);
        check({tag, "_ovf"},   32'(ovf),       0);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: compares every accepted sample against the scoreboard
    // and checks that a stalled sample is held unchanged.
    bit             stall = 1'b0;
    logic [NUM-1:0] h_idx;
    logic [DW-1:0]  h_re, h_im;
    logic           h_last;

    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b0) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_idx",   32'(out_idx),   32'(h_idx));
                check("hold_re",    32'(out_re),    32'(h_re));
                check("hold_im",    32'(out_im),    32'(h_im));
                check("hold_last",  32'(out_last),  32'(h_last));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got idx %0d re %0h expected no sample", out_idx, out_re);
                end else begin
                    e = exp_q.pop_front();
                    check("out_idx",  32'(out_idx),  32'(e.idx));
                    check("out_re",   32'(out_re),   32'(e.re));
                    check("out_im",   32'(out_im),   32'(e.im));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            stall  = (out_valid === 1'b1) && (out_ready === 1'b0);
            h_idx  = out_idx;
            h_re   = out_re;
            h_im   = out_im;
            h_last = out_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        int n;
        int w;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_idx   = '0;
        in_re    = '0;
        in_im    = '0;
        #2 reset = 1'b1;
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        cycles(2);

        // Single frame, latency and first samples.
        push_frame(0);
        send_range(0, 0, N - 1, 1'b1);
        idle_in();
        check("lat_e0", 32'(out_valid), 0);
        cycles(1);
        check("lat_e1", 32'(out_valid), 0);
        cycles(1);
        check("lat_e2", 32'(out_valid), 1);
        check("t1_first_re", 32'(out_re), 0);
        cycles(1);
        check("t1_second_idx", 32'(out_idx), 1);
        check("t1_second_re", 32'(out_re), SECOND_RE);
        wait_drain(400, "t1_drain");
        check("t1_ovf", 32'(ovf), 0);

        // Two back-to-back frames: no bubble across the frame boundary.
        push_frame(0);
        push_frame(128);
        fork
            begin
                send_range(0, 0, N - 1, 1'b1);
                send_range(128, 0, N - 1, 1'b1);
                idle_in();
            end
            begin
                n = 0;
                w = 0;
                while (out_valid !== 1'b1 && w < 600) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                while (out_valid === 1'b1 && n < 600) begin
                    n++;
                    @(posedge clk);
                    #1;
                end
                check("t2_contig", 32'(n), 256);
            end
        join
        wait_drain(400, "t2_drain");

        // Random backpressure.
        ready_mode = 2;
        push_frame(256);
        send_range(256, 0, N - 1, 1'b1);
        idle_in();
        wait_drain(3000, "t3_drain");
        ready_mode = 1;
        cycles(2);

        // in_valid without in_start writes nothing.
        send_range(4096, 0, N - 1, 1'b0);
        idle_in();
        cycles(5);
        check("t5_no_out", 32'(out_valid), 0);
        check("t5_ovf", 32'(ovf), 0);

        // Three frames with the output blocked: third frame overflows.
        ready_mode = 0;
        cycles(2);
        push_frame(512);
        push_frame(640);
        send_range(512, 0, N - 1, 1'b1);
        send_range(640, 0, N - 1, 1'b1);
        check("t4_ovf_pre", 32'(ovf), 0);
        send_range(768, 0, 0, 1'b1);
        check("t4_ovf_first", 32'(ovf), 1);
        send_range(768, 1, N - 1, 1'b1);
        idle_in();
        cycles(3);
        check("t4_stall_valid", 32'(out_valid), 1);
        check("t4_stall_idx", 32'(out_idx), 0);
        ready_mode = 1;
        wait_drain(600, "t4_drain");
        check("t4_ovf_sticky", 32'(ovf), 1);

        // Reset in the middle of a frame.
        send_range(900, 0, 59, 1'b1);
        in_valid = 1'b1;
        in_start = 1'b1;
        in_idx   = NUM'(60);
        in_re    = 16'(960);
        in_im    = ~16'(960);
        reset    = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        idle_in();
        reset = 1'b0;
        cycles(3);
        check("t6_quiet", 32'(out_valid), 0);
        push_frame(1024);
        send_range(1024, 0, N - 1, 1'b1);
        idle_in();
        wait_drain(400, "t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
